dma_copy: RTL and testbench



---
 rtl/dma_pkg.sv | 38 +++
 rtl/dma_regs.sv | 151 +++++++++++++++
 rtl/dma_copy.sv | 149 ++++++++++++++
 tb/tb_dma_copy.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the dma_copy word-copy engine: FSM state encoding,
// register window offsets, CTRL bit positions and a byte-mask merge helper.
// Optional feature macro: DMA_FILL_EN (CTRL bit4 FILL, see dma_regs/dma_copy).
package dma_pkg;

  // FSM state encoding (kept as plain constants for legacy tool flows)
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RD   = 2'd1;
  localparam state_t ST_WR   = 2'd2;
  localparam state_t ST_FIN  = 2'd3;

  // Byte offsets of the four registers inside the 16-byte window
  localparam logic [3:0] OFF_SRC  = 4'h0;
  localparam logic [3:0] OFF_DST  = 4'h4;
  localparam logic [3:0] OFF_LEN  = 4'h8;
  localparam logic [3:0] OFF_CTRL = 4'hC;

  // CTRL register bit positions
  localparam int CTRL_START  = 0;
  localparam int CTRL_BUSY   = 1;
  localparam int CTRL_DONE   = 2;
  localparam int CTRL_IRQ_EN = 3;
  localparam int CTRL_FILL   = 4;

  // Merge new write data into an old register value, one byte lane per mask bit
  function automatic logic [31:0] apply_wrmask(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  mask);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dma_regs.sv
// Responder side of dma_copy: address decode of the 16-byte config window,
// SRC/DST/LEN/CTRL register file and the one-cycle registered valid handshake.
// Optional feature macro: DMA_FILL_EN adds the RW FILL bit (CTRL bit4).
module dma_regs
  import dma_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0004_0000,
  parameter int          LEN_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_rd,
  input  logic [31:0]      i_addr,
  input  logic             i_wr,
  input  logic [3:0]       i_wrmask,
  input  logic [31:0]      i_data,
  output logic             o_rd_valid,
  output logic             o_wr_valid,
  output logic [31:0]      o_data,
  input  logic             busy_i,
  input  logic             fin_i,
  output logic [31:0]      src_o,
  output logic [31:0]      dst_o,
  output logic [LEN_W-1:0] len_o,
  output logic             start_o,
  output logic             fill_o,
  output logic             irq_o
);

  logic             rd_valid_q, rd_valid_d;
  logic             wr_valid_q, wr_valid_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             done_q, done_d;
  logic             irq_en_q, irq_en_d;
  logic             start_q, start_d;

  logic             hit;
  logic             rd_fire;
  logic             wr_fire;
  logic             ctrl_wr;
  logic [31:0]      ctrl_rdata;
  logic [31:0]      readback;

  // A request is accepted only on the cycle after an idle valid, so a held
  // request completes every other cycle and writes land with the valid edge.
  assign hit     = (i_addr[31:4] == BASE_ADDR[31:4]);
  assign rd_fire = i_rd & hit & ~rd_valid_q;
  assign wr_fire = i_wr & hit & ~wr_valid_q;
  assign ctrl_wr = wr_fire & (i_addr[3:0] == OFF_CTRL) & i_wrmask[0];

`ifdef DMA_FILL_EN
  logic fill_q;

  // FILL mode bit, only present when the fill feature is built in
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q <= 1'b0;
    end else if (ctrl_wr) begin
      fill_q <= i_data[CTRL_FILL];
    end
  end

  assign fill_o = fill_q;
`else
  assign fill_o = 1'b0;
`endif

  // Register readback mux; START always reads 0 and BUSY comes from the FSM
  always_comb begin
    ctrl_rdata              = '0;
    ctrl_rdata[CTRL_BUSY]   = busy_i;
    ctrl_rdata[CTRL_DONE]   = done_q;
    ctrl_rdata[CTRL_IRQ_EN] = irq_en_q;
    ctrl_rdata[CTRL_FILL]   = fill_o;
    case (i_addr[3:0])
      OFF_SRC:  readback = src_q;
      OFF_DST:  readback = dst_q;
      OFF_LEN:  readback = 32'(len_q);
      OFF_CTRL: readback = ctrl_rdata;
      default:  readback = '0;
    endcase
  end

  // Next-state for the register file, handshake flags and read data
  always_comb begin
    rd_valid_d = rd_fire;
    wr_valid_d = wr_fire;
    rdata_d    = rd_fire ? readback : '0;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    irq_en_d   = irq_en_q;
    done_d     = done_q;
    start_d    = ctrl_wr & i_data[CTRL_START];

    if (wr_fire) begin
      case (i_addr[3:0])
        OFF_SRC: src_d = apply_wrmask(src_q, i_data, i_wrmask);
        OFF_DST: dst_d = apply_wrmask(dst_q, i_data, i_wrmask);
        OFF_LEN: len_d = LEN_W'(apply_wrmask(32'(len_q), i_data, i_wrmask));
        default: ;
      endcase
    end

    if (ctrl_wr) begin
      irq_en_d = i_data[CTRL_IRQ_EN];
      if (i_data[CTRL_DONE]) done_d = 1'b0;
    end

    // Completion of a transfer outranks a simultaneous W1C
    if (fin_i) done_d = 1'b1;
  end

  // Register update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      wr_valid_q <= 1'b0;
      rdata_q    <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      done_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      rd_valid_q <= rd_valid_d;
      wr_valid_q <= wr_valid_d;
      rdata_q    <= rdata_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      done_q     <= done_d;
      irq_en_q   <= irq_en_d;
      start_q    <= start_d;
    end
  end

  assign o_rd_valid = rd_valid_q;
  assign o_wr_valid = wr_valid_q;
  assign o_data     = rdata_q;
  assign src_o      = src_q;
  assign dst_o      = dst_q;
  assign len_o      = len_q;
  assign start_o    = start_q;
  assign irq_o      = done_q & irq_en_q;

endmodule

// File: rtl/dma_copy.sv
// Single-channel word-copy DMA engine. Holds the transfer FSM and the
// initiator bus port; the config window lives in dma_regs.
// Optional feature macro: DMA_FILL_EN (write SRC's value to every DST word).
module dma_copy
  import dma_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0004_0000,
  parameter int          LEN_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rd,
  input  logic [31:0] i_addr,
  input  logic        i_wr,
  input  logic [3:0]  i_wrmask,
  input  logic [31:0] i_data,
  output logic        o_rd_valid,
  output logic        o_wr_valid,
  output logic [31:0] o_data,
  output logic        o_m_rd,
  output logic [31:0] o_m_addr,
  output logic        o_m_wr,
  output logic [3:0]  o_m_wrmask,
  output logic [31:0] o_m_data,
  input  logic        i_m_rd_valid,
  input  logic        i_m_wr_valid,
  input  logic [31:0] i_m_data,
  output logic        o_irq
);

  logic [31:0]      src;
  logic [31:0]      dst;
  logic [LEN_W-1:0] len;
  logic             start;
  logic             fill;
  logic             busy;
  logic             fin;

  state_t           state_q, state_d;
  logic [31:0]      cur_src_q, cur_src_d;
  logic [31:0]      cur_dst_q, cur_dst_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [31:0]      buf_q, buf_d;
  logic             fill_mode_q, fill_mode_d;

  dma_regs #(
    .BASE_ADDR (BASE_ADDR),
    .LEN_W     (LEN_W)
  ) u_regs (
    .clk        (clk),
    .rst        (rst),
    .i_rd       (i_rd),
    .i_addr     (i_addr),
    .i_wr       (i_wr),
    .i_wrmask   (i_wrmask),
    .i_data     (i_data),
    .o_rd_valid (o_rd_valid),
    .o_wr_valid (o_wr_valid),
    .o_data     (o_data),
    .busy_i     (busy),
    .fin_i      (fin),
    .src_o      (src),
    .dst_o      (dst),
    .len_o      (len),
    .start_o    (start),
    .fill_o     (fill),
    .irq_o      (o_irq)
  );

  assign busy = (state_q == ST_RD) || (state_q == ST_WR);
  assign fin  = (state_q == ST_FIN);

  // Transfer FSM: latch the job on START, then alternate read/write per word
  always_comb begin
    state_d     = state_q;
    cur_src_d   = cur_src_q;
    cur_dst_d   = cur_dst_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    fill_mode_d = fill_mode_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len != '0) begin
            cur_src_d   = src & 32'hFFFF_FFFC;
            cur_dst_d   = dst & 32'hFFFF_FFFC;
            cnt_d       = len;
            buf_d       = src;
            fill_mode_d = fill;
            state_d     = fill ? ST_WR : ST_RD;
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_RD: begin
        if (i_m_rd_valid) begin
          buf_d   = i_m_data;
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        if (i_m_wr_valid) begin
          cur_src_d = cur_src_q + 32'd4;
          cur_dst_d = cur_dst_q + 32'd4;
          cnt_d     = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = ST_FIN;
          end else begin
            state_d = fill_mode_q ? ST_WR : ST_RD;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and datapath registers; reset abandons any transfer in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cur_src_q   <= '0;
      cur_dst_q   <= '0;
      cnt_q       <= '0;
      buf_q       <= '0;
      fill_mode_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_src_q   <= cur_src_d;
      cur_dst_q   <= cur_dst_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      fill_mode_q <= fill_mode_d;
    end
  end

  // Initiator requests are decoded straight from the state register, so they
  // stay stable until the FSM moves on the matching valid
  assign o_m_rd     = (state_q == ST_RD);
  assign o_m_wr     = (state_q == ST_WR);
  assign o_m_addr   = (state_q == ST_RD) ? cur_src_q :
                      (state_q == ST_WR) ? cur_dst_q : 32'd0;
  assign o_m_data   = (state_q == ST_WR) ? buf_q : 32'd0;
  assign o_m_wrmask = 4'hF;

endmodule

// File: tb/tb_dma_copy.sv
// Self-checking bench for dma_copy: a memory responder model answers the
// initiator port and checks every read address and written word against
// queues filled by a word-level reference model of each transfer.
// Honours DMA_FILL_EN when the macro is defined for the build.
module tb_dma_copy;

  localparam logic [31:0] BASE  = 32'h0004_0000;
  localparam logic [31:0] A_SRC  = BASE + 32'h0;
  localparam logic [31:0] A_DST  = BASE + 32'h4;
  localparam logic [31:0] A_LEN  = BASE + 32'h8;
  localparam logic [31:0] A_CTRL = BASE + 32'hC;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_rd;
  logic [31:0] i_addr;
  logic        i_wr;
  logic [3:0]  i_wrmask;
  logic [31:0] i_data;
  logic        o_rd_valid;
  logic        o_wr_valid;
  logic [31:0] o_data;
  logic        o_m_rd;
  logic [31:0] o_m_addr;
  logic        o_m_wr;
  logic [3:0]  o_m_wrmask;
  logic [31:0] o_m_data;
  logic        i_m_rd_valid;
  logic        i_m_wr_valid;
  logic [31:0] i_m_data;
  logic        o_irq;

  int checks = 0;
  int errors = 0;
  int rdCycles = 0;
  int wrCycles = 0;
  int memLat = 2;
  bit holdWr = 1'b0;

  logic [31:0] expRd[$];
  xfer_t       expWr[$];
  logic [31:0] memOverride [logic [31:0]];

  dma_copy dut (
    .clk          (clk),
    .rst          (rst),
    .i_rd         (i_rd),
    .i_addr       (i_addr),
    .i_wr         (i_wr),
    .i_wrmask     (i_wrmask),
    .i_data       (i_data),
    .o_rd_valid   (o_rd_valid),
    .o_wr_valid   (o_wr_valid),
    .o_data       (o_data),
    .o_m_rd       (o_m_rd),
    .o_m_addr     (o_m_addr),
    .o_m_wr       (o_m_wr),
    .o_m_wrmask   (o_m_wrmask),
    .o_m_data     (o_m_data),
    .i_m_rd_valid (i_m_rd_valid),
    .i_m_wr_valid (i_m_wr_valid),
    .i_m_data     (i_m_data),
    .o_irq        (o_irq)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  // Memory contents seen by the engine: a fixed scramble of the address
  // unless a directed test planted a specific word
  function automatic logic [31:0] memRead(input logic [31:0] addr);
    if (memOverride.exists(addr)) return memOverride[addr];
    return (addr * 32'h9E37_79B9) ^ 32'h5A5A_A5A5;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Responder-port write, held until the DUT raises o_wr_valid
  task automatic busWrite(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] mask);
    bit seen = 1'b0;
    i_wr = 1'b1; i_addr = addr; i_data = data; i_wrmask = mask;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk); #1;
      if (o_wr_valid) seen = 1'b1;
    end
    i_wr = 1'b0; i_data = '0; i_wrmask = '0;
    if (!seen) checkOutput("wr_valid timeout", 32'd0, 32'd1);
  endtask

  // Responder-port read, data captured with o_rd_valid
  task automatic busRead(input logic [31:0] addr, output logic [31:0] data);
    bit seen = 1'b0;
    data = '0;
    i_rd = 1'b1; i_addr = addr;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk); #1;
      if (o_rd_valid) begin
        seen = 1'b1;
        data = o_data;
      end
    end
    i_rd = 1'b0;
    if (!seen) checkOutput("rd_valid timeout", 32'd0, 32'd1);
  endtask

  task automatic readCheck(input string name, input logic [31:0] addr,
                           input logic [31:0] expected);
    logic [31:0] v;
    busRead(addr, v);
    checkOutput(name, v, expected);
  endtask

  // Reference model: expected word stream for one job, then program and START
  task automatic applyStimulus(input logic [31:0] src, input logic [31:0] dst,
                               input logic [15:0] len, input logic [31:0] ctrlBits);
    bit fillOn;
    logic [31:0] aS, aD;
    xfer_t x;
`ifdef DMA_FILL_EN
    fillOn = ctrlBits[4];
`else
    fillOn = 1'b0;
`endif
    for (int i = 0; i < int'(len); i++) begin
      aS = (src & 32'hFFFF_FFFC) + 32'(4 * i);
      aD = (dst & 32'hFFFF_FFFC) + 32'(4 * i);
      if (!fillOn) expRd.push_back(aS);
      x.addr = aD;
      x.data = fillOn ? src : memRead(aS);
      expWr.push_back(x);
    end
    busWrite(A_SRC, src, 4'hF);
    busWrite(A_DST, dst, 4'hF);
    busWrite(A_LEN, 32'(len), 4'hF);
    busWrite(A_CTRL, ctrlBits | 32'h1, 4'hF);
  endtask

  task automatic waitDone(input string name);
    logic [31:0] v;
    bit done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      busRead(A_CTRL, v);
      if (v[2]) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL %s DONE timeout actual=0 expected=1", name);
    end
    checkOutput({name, " reads left"}, 32'(expRd.size()), 32'd0);
    checkOutput({name, " writes left"}, 32'(expWr.size()), 32'd0);
  endtask

  // Memory responder and monitor: answers requests after memLat samples and
  // pops the scoreboard queues for every accepted transaction
  initial begin
    int latCnt;
    logic [31:0] expA;
    xfer_t x;
    latCnt = 0;
    i_m_rd_valid = 1'b0; i_m_wr_valid = 1'b0; i_m_data = '0;
    forever begin
      @(posedge clk); #1;
      if (o_m_rd === 1'b1) rdCycles++;
      if (o_m_wr === 1'b1) wrCycles++;
      if (o_rd_valid !== 1'b1 && o_data !== 32'd0)
        checkOutput("o_data idle zero", o_data, 32'd0);
      if (i_m_rd_valid || i_m_wr_valid) begin
        i_m_rd_valid = 1'b0; i_m_wr_valid = 1'b0; i_m_data = '0; latCnt = 0;
      end else if ((o_m_rd === 1'b1 || o_m_wr === 1'b1) && rst !== 1'b1) begin
        if (o_m_rd === 1'b1 && o_m_wr === 1'b1)
          checkOutput("rd and wr together", 32'd1, 32'd0);
        if (latCnt < memLat) begin
          latCnt++;
        end else if (o_m_rd === 1'b1) begin
          if (expRd.size() == 0) begin
            checkOutput("unexpected read", o_m_addr, 32'hFFFF_FFFF);
          end else begin
            expA = expRd.pop_front();
            checkOutput("read addr", o_m_addr, expA);
          end
          i_m_data = memRead(o_m_addr);
          i_m_rd_valid = 1'b1;
        end else if (!holdWr) begin
          checkOutput("write mask", 32'(o_m_wrmask), 32'hF);
          if (expWr.size() == 0) begin
            checkOutput("unexpected write", o_m_addr, 32'hFFFF_FFFF);
          end else begin
            x = expWr.pop_front();
            checkOutput("write addr", o_m_addr, x.addr);
            checkOutput("write data", o_m_data, x.data);
          end
          i_m_wr_valid = 1'b1;
        end
      end else begin
        latCnt = 0;
      end
    end
  end

  // Directed scenarios followed by randomized transfers
  initial begin
    logic [31:0] v;
    int r0, w0;
    bit seen;
    rst = 1'b1; i_rd = 1'b0; i_wr = 1'b0; i_addr = '0; i_wrmask = '0; i_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset outputs", {27'd0, o_rd_valid, o_wr_valid, o_m_rd, o_m_wr, o_irq}, 32'd0);
    checkOutput("reset o_data", o_data, 32'd0);
    checkOutput("reset m_addr", o_m_addr, 32'd0);
    rst = 1'b0;
    readCheck("reset SRC", A_SRC, 32'd0);
    readCheck("reset DST", A_DST, 32'd0);
    readCheck("reset LEN", A_LEN, 32'd0);
    readCheck("reset CTRL", A_CTRL, 32'd0);

    // Byte-masked writes and LEN truncation
    busWrite(A_SRC, 32'hAABB_CCDD, 4'b0101);
    readCheck("SRC byte mask", A_SRC, 32'h00BB_00DD);
    busWrite(A_LEN, 32'hFFFF_1234, 4'hF);
    readCheck("LEN width", A_LEN, 32'h0000_1234);

    // Three-word copy with a two-cycle memory
    memOverride[32'h100] = 32'hA;
    memOverride[32'h104] = 32'hB;
    memOverride[32'h108] = 32'hC;
    memLat = 2;
    applyStimulus(32'h100, 32'h200, 16'd3, 32'h0);
    waitDone("copy3");
    readCheck("copy3 CTRL", A_CTRL, 32'h4);
    busWrite(A_CTRL, 32'h4, 4'hF);
    readCheck("DONE W1C", A_CTRL, 32'h0);

    // Zero-length job: no bus traffic, DONE (seen via IRQ) two cycles later
    r0 = rdCycles; w0 = wrCycles;
    applyStimulus(32'h700, 32'h800, 16'd0, 32'h8);
    checkOutput("len0 irq +0", 32'(o_irq), 32'd0);
    @(posedge clk); #1;
    checkOutput("len0 irq +1", 32'(o_irq), 32'd0);
    @(posedge clk); #1;
    checkOutput("len0 irq +2", 32'(o_irq), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("len0 rd cycles", 32'(rdCycles - r0), 32'd0);
    checkOutput("len0 wr cycles", 32'(wrCycles - w0), 32'd0);
    readCheck("len0 CTRL", A_CTRL, 32'hC);
    busWrite(A_CTRL, 32'h4, 4'hF);

    // Interrupt on a real transfer, cleared by W1C
    applyStimulus(32'h1000, 32'h2000, 16'd2, 32'h8);
    waitDone("irq job");
    checkOutput("irq set", 32'(o_irq), 32'd1);
    busWrite(A_CTRL, 32'h4, 4'hF);
    checkOutput("irq cleared", 32'(o_irq), 32'd0);

    // Source address wraps through zero
    applyStimulus(32'hFFFF_FFFC, 32'h3000, 16'd2, 32'h0);
    waitDone("wrap");
    busWrite(A_CTRL, 32'h4, 4'hF);

    // Reset while a write is held off
    holdWr = 1'b1;
    applyStimulus(32'h500, 32'h600, 16'd3, 32'h0);
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(posedge clk); #1;
      if (o_m_wr) seen = 1'b1;
    end
    checkOutput("reach WR", 32'(seen), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst drops m_wr", 32'(o_m_wr), 32'd0);
    checkOutput("rst drops m_rd", 32'(o_m_rd), 32'd0);
    checkOutput("rst o_data", o_data, 32'd0);
    rst = 1'b0;
    holdWr = 1'b0;
    expRd.delete();
    expWr.delete();
    readCheck("rst SRC", A_SRC, 32'd0);
    readCheck("rst DST", A_DST, 32'd0);
    readCheck("rst LEN", A_LEN, 32'd0);
    readCheck("rst CTRL", A_CTRL, 32'd0);

`ifdef DMA_FILL_EN
    // Fill mode: every destination word gets SRC, no reads at all
    r0 = rdCycles;
    applyStimulus(32'hDEAD_BEEF, 32'h4000, 16'd2, 32'h10);
    waitDone("fill");
    checkOutput("fill rd cycles", 32'(rdCycles - r0), 32'd0);
    readCheck("fill CTRL", A_CTRL, 32'h14);
    busWrite(A_CTRL, 32'h4, 4'hF);
`else
    busWrite(A_CTRL, 32'h10, 4'hF);
    readCheck("FILL absent", A_CTRL, 32'h0);
`endif

    // Randomized jobs
    for (int t = 0; t < 8; t++) begin
      logic [31:0] src, dst, ctrl;
      logic [15:0] len;
      src = $urandom;
      dst = $urandom;
      len = 16'($urandom_range(1, 5));
      memLat = $urandom_range(0, 3);
      ctrl = $urandom_range(0, 1) ? 32'h8 : 32'h0;
`ifdef DMA_FILL_EN
      if ($urandom_range(0, 1) == 1) ctrl = ctrl | 32'h10;
`endif
      applyStimulus(src, dst, len, ctrl);
      waitDone("random");
      readCheck("random CTRL", A_CTRL, ctrl | 32'h4);
      checkOutput("random irq", 32'(o_irq), 32'(ctrl[3]));
      busWrite(A_CTRL, 32'h4, 4'hF);
    end

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
